// File: rtl/vscpu_boot_pkg.sv
// Shared constants and state encoding for the RAM boot loader.
package vscpu_boot_pkg;

  // Frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_CNT_HI  = 3'd3,
    ST_CNT_LO  = 3'd4,
    ST_DATA    = 3'd5,
    ST_CHECK   = 3'd6
  } state_t;

endpackage

// File: rtl/ram_boot_loader.sv
// Boot loader: parses framed UART bytes into 32-bit RAM writes while holding
// the CPU in reset; otherwise the CPU's RAM port passes straight through.
module ram_boot_loader
  import vscpu_boot_pkg::*;
#(
  parameter int unsigned SIZE      = 14,
  parameter int unsigned BOOT_WAIT = 1,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rx_valid,
  input  logic [7:0]      i_rx_byte,
  input  logic            i_cpu_we,
  input  logic [SIZE-1:0] i_cpu_addr,
  input  logic [31:0]     i_cpu_data,
  output logic            o_we,
  output logic [SIZE-1:0] o_addr,
  output logic [31:0]     o_data,
  output logic            o_cpu_rst,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [SIZE-1:0] addr;
  logic [7:0]      addr_hi;
  logic [15:0]     cnt;
  logic [1:0]      byte_idx;
  logic [23:0]     word;
  logic [7:0]      chk;
  logic [TW-1:0]   timer;
  logic            ld_we;
  logic [SIZE-1:0] ld_addr;
  logic [31:0]     ld_data;
  logic            cpu_rst;
  logic            done;
  logic            err;

  logic [31:0]     word_next;
  logic [15:0]     cnt_full;

  assign word_next = {word, i_rx_byte};
  assign cnt_full  = {cnt[15:8], i_rx_byte};

  // Frame parser, word assembly, RAM write strobe and inter-byte timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      addr_hi  <= '0;
      cnt      <= '0;
      byte_idx <= '0;
      word     <= '0;
      chk      <= '0;
      timer    <= '0;
      ld_we    <= 1'b0;
      ld_addr  <= '0;
      ld_data  <= '0;
      cpu_rst  <= 1'(BOOT_WAIT);
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ld_we <= 1'b0;
      if (state == ST_IDLE) begin
        if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) begin
          state    <= ST_ADDR_HI;
          cpu_rst  <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
          chk      <= '0;
          byte_idx <= '0;
          timer    <= '0;
        end
      end else if (i_rx_valid) begin
        // A byte in the expiry cycle lands here and pre-empts the timeout
        timer <= '0;
        chk   <= chk ^ i_rx_byte;
        case (state)
          ST_ADDR_HI: begin
            addr_hi <= i_rx_byte;
            state   <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr  <= SIZE'({addr_hi, i_rx_byte});
            state <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            cnt   <= {i_rx_byte, 8'h00};
            state <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            cnt      <= cnt_full;
            byte_idx <= '0;
            state    <= (cnt_full == 16'd0) ? ST_CHECK : ST_DATA;
          end
          ST_DATA: begin
            word     <= word_next[23:0];
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              ld_we   <= 1'b1;
              ld_addr <= addr;
              ld_data <= word_next;
              addr    <= addr + SIZE'(1);
              cnt     <= cnt - 16'd1;
              if (cnt == 16'd1) state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            state <= ST_IDLE;
            if (chk == i_rx_byte) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timer == TW'(TIMEOUT - 1)) begin
        err   <= 1'b1;
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

  // RAM port mux: loader owns the port while the CPU is held in reset
  assign o_we      = cpu_rst ? ld_we   : i_cpu_we;
  assign o_addr    = cpu_rst ? ld_addr : i_cpu_addr;
  assign o_data    = cpu_rst ? ld_data : i_cpu_data;
  assign o_cpu_rst = cpu_rst;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = done;
  assign o_err     = err;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Bench for ram_boot_loader: two instances (BOOT_WAIT=1 and 0) share the same
// stimulus; a frame-level model predicts flags and RAM writes every cycle.
module tb_ram_boot_loader;

  localparam int unsigned SIZE  = 14;
  localparam int          DEPTH = 1 << SIZE;
  localparam int          TMO   = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            cpu_we;
  logic [SIZE-1:0] cpu_addr;
  logic [31:0]     cpu_data;

  logic            we_s      [2];
  logic [SIZE-1:0] addr_s    [2];
  logic [31:0]     data_s    [2];
  logic            cpu_rst_s [2];
  logic            busy_s    [2];
  logic            done_s    [2];
  logic            err_s     [2];

  always #5 clk = ~clk;

  ram_boot_loader #(.SIZE(SIZE), .BOOT_WAIT(1), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_we(we_s[0]), .o_addr(addr_s[0]), .o_data(data_s[0]),
    .o_cpu_rst(cpu_rst_s[0]), .o_busy(busy_s[0]), .o_done(done_s[0]), .o_err(err_s[0])
  );

  ram_boot_loader #(.SIZE(SIZE), .BOOT_WAIT(0), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_we(we_s[1]), .o_addr(addr_s[1]), .o_data(data_s[1]),
    .o_cpu_rst(cpu_rst_s[1]), .o_busy(busy_s[1]), .o_done(done_s[1]), .o_err(err_s[1])
  );

  // Frame-level model state
  logic        m_busy, m_done, m_err;
  logic        m_cpu_rst [2];
  int          m_pos, m_cnt, m_addr, m_gap;
  logic [7:0]  m_ahi, m_chi, m_chk;
  logic [31:0] m_word;
  logic        exp_wr;
  int          exp_waddr;
  logic [31:0] exp_wdata;

  // Observed writes from instance A (acts as the RAM behind it)
  int          wr_count;
  logic [31:0] ram [int];
  int          last_wr_addr;
  logic [31:0] last_wr_data;

  int   checks = 0;
  int   errors = 0;
  logic hold_cpu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_cpu_rst[0] = 1'b1; m_cpu_rst[1] = 1'b0;
    m_gap = 0; exp_wr = 1'b0;
  endtask

  // Apply the frame rules to one accepted byte
  task automatic model_byte(input logic [7:0] b);
    m_gap = 0;
    if (!m_busy) begin
      if (b == 8'hA5) begin
        m_busy = 1'b1; m_pos = 0; m_chk = 8'h00;
        m_done = 1'b0; m_err = 1'b0;
        m_cpu_rst[0] = 1'b1; m_cpu_rst[1] = 1'b1;
      end
    end else begin
      if (m_pos == 0) m_ahi = b;
      else if (m_pos == 1) m_addr = int'({m_ahi, b}) % DEPTH;
      else if (m_pos == 2) m_chi = b;
      else if (m_pos == 3) m_cnt = int'({m_chi, b});
      else if (m_pos < 4 + 4 * m_cnt) begin
        m_word = {m_word[23:0], b};
        if ((m_pos - 3) % 4 == 0) begin
          exp_wr = 1'b1; exp_waddr = m_addr; exp_wdata = m_word;
          m_addr = (m_addr + 1) % DEPTH;
        end
      end
      if (m_pos >= 4 && m_pos == 4 + 4 * m_cnt) begin
        if (b == m_chk) begin
          m_done = 1'b1; m_cpu_rst[0] = 1'b0; m_cpu_rst[1] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_busy = 1'b0;
      end else begin
        m_chk = m_chk ^ b;
      end
      m_pos++;
    end
  endtask

  task automatic model_idle();
    if (m_busy) begin
      m_gap++;
      if (m_gap == TMO) begin
        m_err = 1'b1; m_busy = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance, update the model
  task automatic cycle(input logic v, input logic [7:0] b);
    rx_valid = v; rx_byte = b;
    if (!hold_cpu) begin
      cpu_we = 1'($urandom_range(0, 1)); cpu_addr = SIZE'($urandom); cpu_data = $urandom;
    end
    @(posedge clk); #1;
    exp_wr = 1'b0;
    if (!rst) begin
      if (v) model_byte(b);
      else model_idle();
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 85) return 0;
    if (r < 95) return $urandom_range(1, 3);
    if (r < 98) return TMO - 1;
    return TMO;
  endfunction

  task automatic send(input logic [7:0] q[$], input bit rgap);
    foreach (q[i]) begin
      if (rgap && i > 0) idle(rand_gap());
      cycle(1'b1, q[i]);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i < q.size(); i++) s = s ^ q[i];
    return s;
  endfunction

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("cpu_rst%0d", k), 32'(cpu_rst_s[k]), 32'(m_cpu_rst[k]));
      check($sformatf("busy%0d", k), 32'(busy_s[k]), 32'(m_busy));
      check($sformatf("done%0d", k), 32'(done_s[k]), 32'(m_done));
      check($sformatf("err%0d", k), 32'(err_s[k]), 32'(m_err));
      if (m_cpu_rst[k]) begin
        check($sformatf("ld_we%0d", k), 32'(we_s[k]), 32'(exp_wr));
        if (exp_wr) begin
          check($sformatf("ld_addr%0d", k), 32'(addr_s[k]), 32'(exp_waddr));
          check($sformatf("ld_data%0d", k), data_s[k], exp_wdata);
        end
      end else begin
        check($sformatf("pt_we%0d", k), 32'(we_s[k]), 32'(cpu_we));
        check($sformatf("pt_addr%0d", k), 32'(addr_s[k]), 32'(cpu_addr));
        check($sformatf("pt_data%0d", k), data_s[k], cpu_data);
      end
    end
    if (we_s[0] && cpu_rst_s[0]) begin
      wr_count++;
      ram[int'(addr_s[0])] = data_s[0];
      last_wr_addr = int'(addr_s[0]);
      last_wr_data = data_s[0];
    end
  end

  initial begin
    logic [7:0] fr[$];
    int wc0;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    hold_cpu = 1'b0; wr_count = 0; last_wr_addr = -1; last_wr_data = '0;
    m_pos = 0; m_cnt = 0; m_addr = 0; m_ahi = 0; m_chi = 0; m_chk = 0; m_word = 0;
    exp_waddr = 0; exp_wdata = 0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset values
    check("reset_cpu_rst_a", 32'(cpu_rst_s[0]), 32'd1);
    check("reset_cpu_rst_b", 32'(cpu_rst_s[1]), 32'd0);
    check("reset_busy_a", 32'(busy_s[0]), 32'd0);
    check("reset_done_a", 32'(done_s[0]), 32'd0);
    check("reset_err_a", 32'(err_s[0]), 32'd0);

    // Good single-word frame
    wc0 = wr_count;
    fr = '{8'hA5, 8'h00, 8'h1E, 8'h00, 8'h01, 8'h20, 8'h02, 8'h80, 8'h0A, 8'hB7};
    send(fr, 1'b0);
    idle(1);
    check("good_wr_count", 32'(wr_count), 32'(wc0 + 1));
    check("good_wr_addr", 32'(last_wr_addr), 32'd30);
    check("good_wr_data", last_wr_data, 32'h2002800A);
    check("good_ram30", ram.exists(30) ? ram[30] : 32'hDEADBEEF, 32'h2002800A);
    check("good_done", 32'(done_s[0]), 32'd1);
    check("good_cpu_rst", 32'(cpu_rst_s[0]), 32'd0);

    // Bad checksum: write still lands
    wc0 = wr_count;
    fr = '{8'hA5, 8'h00, 8'h1E, 8'h00, 8'h01, 8'h20, 8'h02, 8'h80, 8'h0A, 8'hB6};
    send(fr, 1'b0);
    idle(1);
    check("bad_wr_count", 32'(wr_count), 32'(wc0 + 1));
    check("bad_err", 32'(err_s[0]), 32'd1);
    check("bad_done", 32'(done_s[0]), 32'd0);
    check("bad_cpu_rst", 32'(cpu_rst_s[0]), 32'd1);

    // Address wrap
    fr = '{8'hA5, 8'h3F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88};
    fr.push_back(xsum(fr));
    send(fr, 1'b0);
    idle(1);
    check("wrap_ram3fff", ram.exists(16'h3FFF) ? ram[16'h3FFF] : 32'hDEADBEEF, 32'h11223344);
    check("wrap_ram0", ram.exists(0) ? ram[0] : 32'hDEADBEEF, 32'h55667788);
    check("wrap_last_addr", 32'(last_wr_addr), 32'd0);

    // CNT=0 frame
    wc0 = wr_count;
    fr = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05};
    send(fr, 1'b0);
    idle(1);
    check("cnt0_wr_count", 32'(wr_count), 32'(wc0));
    check("cnt0_done", 32'(done_s[0]), 32'd1);

    // Timeout after A5 00
    fr = '{8'hA5, 8'h00};
    send(fr, 1'b0);
    idle(TMO - 1);
    check("tmo_before_err", 32'(err_s[0]), 32'd0);
    check("tmo_before_busy", 32'(busy_s[0]), 32'd1);
    idle(1);
    check("tmo_err", 32'(err_s[0]), 32'd1);
    check("tmo_busy", 32'(busy_s[0]), 32'd0);
    check("tmo_cpu_rst", 32'(cpu_rst_s[0]), 32'd1);
    fr = '{8'hA5, 8'h00, 8'h1E, 8'h00, 8'h01, 8'h20, 8'h02, 8'h80, 8'h0A, 8'hB7};
    send(fr, 1'b0);
    idle(1);
    check("tmo_recover_done", 32'(done_s[0]), 32'd1);

    // Byte in the expiry cycle wins
    cycle(1'b1, 8'hA5);
    idle(TMO - 1);
    fr = '{8'h00, 8'h1E, 8'h00, 8'h01, 8'h20, 8'h02, 8'h80, 8'h0A, 8'hB7};
    send(fr, 1'b0);
    idle(1);
    check("expiry_done", 32'(done_s[0]), 32'd1);
    check("expiry_err", 32'(err_s[0]), 32'd0);

    // Pass-through on the BOOT_WAIT=0 instance, then blocked by A5
    do_reset();
    hold_cpu = 1'b1;
    cpu_we = 1'b1; cpu_addr = '0; cpu_data = 32'h10028005;
    idle(1);
    check("pt_we_b", 32'(we_s[1]), 32'd1);
    check("pt_addr_b", 32'(addr_s[1]), 32'd0);
    check("pt_data_b", data_s[1], 32'h10028005);
    check("pt_we_a_held", 32'(we_s[0]), 32'd0);
    cycle(1'b1, 8'hA5);
    check("pt_block_cpu_rst_b", 32'(cpu_rst_s[1]), 32'd1);
    check("pt_block_we_b", 32'(we_s[1]), 32'd0);
    hold_cpu = 1'b0;

    // Reset after 3 of 4 data bytes
    do_reset();
    fr = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    send(fr, 1'b0);
    wc0 = wr_count;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_busy", 32'(busy_s[0]), 32'd0);
    check("midrst_cpu_rst_a", 32'(cpu_rst_s[0]), 32'd1);
    check("midrst_cpu_rst_b", 32'(cpu_rst_s[1]), 32'd0);
    check("midrst_done", 32'(done_s[0]), 32'd0);
    check("midrst_err", 32'(err_s[0]), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("midrst_no_write", 32'(wr_count), 32'(wc0));

    // Randomized frames with junk, gaps, timeouts and bad checksums
    for (int f = 0; f < 60; f++) begin
      int n_junk, cnt;
      logic [7:0] b;
      n_junk = $urandom_range(0, 2);
      for (int j = 0; j < n_junk; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        cycle(1'b1, b);
      end
      cnt = $urandom_range(0, 3);
      fr = '{8'hA5, 8'($urandom), 8'($urandom), 8'h00, 8'(cnt)};
      for (int j = 0; j < 4 * cnt; j++) fr.push_back(8'($urandom));
      fr.push_back(xsum(fr) ^ (($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00));
      send(fr, 1'b1);
      idle($urandom_range(1, 3));
    end
    idle(TMO + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
